led_allocator: RTL and testbench

Upstream stage of the LED output path. Accepts one frame of per-bin note amplitudes and hues, then computes:
- each bin's share of the LED string, proportional to its amplitude;
- each bin's 24-bit RGB colour word.

It presents both as a stable, atomically updated array set with a level `start` qualifier. This drives the `rgb` / `LEDCounts` / `start` inputs of the WS2801 serializer directly.

---
 rtl/led_allocator_pkg.sv | 35 +++
 rtl/led_allocator_serial_divider.sv | 80 ++++++++
 rtl/led_allocator.sv | 198 +++++++++++++++++++
 tb/tb_led_allocator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_allocator_pkg.sv
// Shared definitions for the LED allocator.
//   state_e  : allocator FSM states
//   quot_w   : width of a per-bin LED count quotient for a given LED total
//   hue2rgb  : 8-bit colour-wheel hue to packed {R,G,B} word
package led_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_DIV,
    ST_COMMIT
  } state_e;

  // A bin can claim every LED, so the quotient must hold LEDS itself.
  function automatic int quot_w(input int leds);
    return $clog2(leds + 1);
  endfunction

  // Three 85-step segments; within a segment one primary ramps down while
  // the next ramps up, so the sum of the two active channels stays at 255.
  function automatic logic [23:0] hue2rgb(input logic [7:0] h);
    logic [7:0] hp;
    logic [7:0] up;
    logic [7:0] dn;
    if (h < 8'd85)       hp = h;
    else if (h < 8'd170) hp = h - 8'd85;
    else                 hp = h - 8'd170;
    up = hp * 8'd3;
    dn = 8'd255 - up;
    if (h < 8'd85)       return {dn, up, 8'd0};
    else if (h < 8'd170) return {8'd0, dn, up};
    else                 return {up, 8'd0, dn};
  endfunction

endpackage

// File: rtl/led_allocator_serial_divider.sv
// Restoring serial divider: one load cycle, then one quotient bit per cycle,
// MSB first.  The caller guarantees the quotient fits in QUO_W bits, so the
// upper dividend bits are already smaller than the divisor and can seed the
// partial remainder directly.
//   clk, rst  : clock, synchronous active-high reset (control only)
//   load      : capture dividend/divisor and start a divide
//   dividend  : DVD_W-bit unsigned numerator
//   divisor   : DVS_W-bit unsigned denominator (non-zero)
//   quotient  : QUO_W-bit result, valid while done is high
//   done      : one-cycle pulse, QUO_W cycles after load
module serial_divider #(
  parameter int DVD_W = 22,
  parameter int DVS_W = 20,
  parameter int QUO_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [QUO_W-1:0] quotient,
  output logic             done
);

  localparam int REM_W = DVS_W + 1;
  localparam int CNT_W = $clog2(QUO_W + 1);

  logic [REM_W-1:0] rem_q, rem_d, trial;
  logic [QUO_W-1:0] lo_q, lo_d;
  logic [QUO_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    rem_d  = rem_q;
    lo_d   = lo_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    trial  = {rem_q[REM_W-2:0], lo_q[QUO_W-1]};
    if (load) begin
      rem_d = REM_W'(dividend >> QUO_W);
      lo_d  = dividend[QUO_W-1:0];
      dvs_d = divisor;
      quo_d = '0;
      cnt_d = CNT_W'(QUO_W);
    end else if (cnt_q != '0) begin
      lo_d = lo_q << 1;
      if (trial >= {1'b0, dvs_q}) begin
        rem_d = trial - {1'b0, dvs_q};
        quo_d = {quo_q[QUO_W-2:0], 1'b1};
      end else begin
        rem_d = trial;
        quo_d = {quo_q[QUO_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
    rem_q <= rem_d;
    lo_q  <= lo_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/led_allocator.sv
// LED allocator: takes one frame of per-bin amplitudes and hues, splits the
// LED string between bins in proportion to amplitude, converts each hue to
// an RGB word, and publishes both arrays atomically for the serializer.
//   clk, rst    : clock, synchronous active-high reset
//   amplitudes  : per-bin unsigned amplitude
//   hues        : per-bin hue (top 8 bits used)
//   in_valid    : frame request, ignored while busy
//   busy        : frame computation in progress
//   rgb         : per-bin {R,G,B} colour word
//   LEDCounts   : per-bin LED count, sum never exceeds LEDS
//   start       : level, outputs hold a completed frame (sticky until reset)
//   frame_done  : one-cycle pulse when the outputs change
module led_allocator
  import led_allocator_pkg::*;
#(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int AMP_W   = 16,
  parameter int HUE_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BIN_QTY-1:0][AMP_W-1:0]         amplitudes,
  input  logic [BIN_QTY-1:0][HUE_W-1:0]         hues,
  input  logic                                  in_valid,
  output logic                                  busy,
  output logic [BIN_QTY-1:0][23:0]              rgb,
  output logic [BIN_QTY-1:0][$clog2(LEDS)-1:0]  LEDCounts,
  output logic                                  start,
  output logic                                  frame_done
);

  localparam int QW      = quot_w(LEDS);
  localparam int CNT_W   = $clog2(LEDS);
  localparam int CNT_MAX = (2 ** CNT_W) - 1;
  localparam int ACC_W   = AMP_W + $clog2(BIN_QTY);
  localparam int DVD_W   = AMP_W + QW;
  localparam int IDX_W   = $clog2(BIN_QTY);
  localparam int STEP_W  = $clog2(QW + 1);

  state_e                          state_q, state_d;
  logic                            busy_q, busy_d;
  logic                            start_q, start_d;
  logic                            frame_done_q, frame_done_d;
  logic [IDX_W-1:0]                bin_q, bin_d;
  logic [STEP_W-1:0]               step_q, step_d;
  logic [IDX_W-1:0]                div_bin_q, div_bin_d;
  logic [ACC_W-1:0]                total_q, total_d;
  logic [BIN_QTY-1:0][AMP_W-1:0]   amp_q, amp_d;
  logic [BIN_QTY-1:0][HUE_W-1:0]   hue_q, hue_d;
  logic [BIN_QTY-1:0][CNT_W-1:0]   stage_cnt_q, stage_cnt_d;
  logic [BIN_QTY-1:0][23:0]        stage_rgb;
  logic [BIN_QTY-1:0][23:0]        rgb_q, rgb_d;
  logic [BIN_QTY-1:0][CNT_W-1:0]   led_counts_q, led_counts_d;

  logic             div_load;
  logic [DVD_W-1:0] div_dividend;
  logic [QW-1:0]    div_quotient;
  logic             div_done;

  // Only reachable when LEDS is a power of two and one bin holds everything.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [QW-1:0] q);
    if (q > QW'(CNT_MAX)) return {CNT_W{1'b1}};
    else                  return CNT_W'(q);
  endfunction

  assign div_dividend = DVD_W'(amp_q[bin_q]) * DVD_W'(LEDS);

  serial_divider #(
    .DVD_W (DVD_W),
    .DVS_W (ACC_W),
    .QUO_W (QW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (total_q),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_comb begin
    for (int i = 0; i < BIN_QTY; i++) begin
      stage_rgb[i] = hue2rgb(hue_q[i][HUE_W-1 -: 8]);
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    start_d      = start_q;
    frame_done_d = 1'b0;
    bin_d        = bin_q;
    step_d       = step_q;
    div_bin_d    = div_bin_q;
    total_d      = total_q;
    amp_d        = amp_q;
    hue_d        = hue_q;
    stage_cnt_d  = stage_cnt_q;
    rgb_d        = rgb_q;
    led_counts_d = led_counts_q;
    div_load     = 1'b0;

    // A divide finishes one cycle after its last bit: during the next bin's
    // load cycle, or during COMMIT for the final bin.
    if (div_done) begin
      stage_cnt_d[div_bin_q] = sat_cnt(div_quotient);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          amp_d       = amplitudes;
          hue_d       = hues;
          total_d     = '0;
          bin_d       = '0;
          step_d      = '0;
          stage_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = ST_SUM;
        end
      end
      ST_SUM: begin
        total_d = total_q + ACC_W'(amp_q[bin_q]);
        if (bin_q == IDX_W'(BIN_QTY - 1)) begin
          bin_d   = '0;
          step_d  = '0;
          state_d = ST_DIV;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      ST_DIV: begin
        // With a zero total the counts stay cleared, but the slot timing is
        // kept so frame latency never depends on the data.
        if (step_q == '0 && total_q != '0) begin
          div_load  = 1'b1;
          div_bin_d = bin_q;
        end
        if (step_q == STEP_W'(QW)) begin
          step_d = '0;
          if (bin_q == IDX_W'(BIN_QTY - 1)) begin
            bin_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        rgb_d        = stage_rgb;
        led_counts_d = stage_cnt_d;
        start_d      = 1'b1;
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      bin_q        <= '0;
      step_q       <= '0;
      rgb_q        <= '0;
      led_counts_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      bin_q        <= bin_d;
      step_q       <= step_d;
      rgb_q        <= rgb_d;
      led_counts_q <= led_counts_d;
    end
    div_bin_q   <= div_bin_d;
    total_q     <= total_d;
    amp_q       <= amp_d;
    hue_q       <= hue_d;
    stage_cnt_q <= stage_cnt_d;
  end

  assign busy       = busy_q;
  assign start      = start_q;
  assign frame_done = frame_done_q;
  assign rgb        = rgb_q;
  assign LEDCounts  = led_counts_q;

endmodule

// File: tb/tb_led_allocator.sv
// Self-checking bench for led_allocator: directed frames plus randomized
// frames compared against an arithmetic reference model.
module tb_led_allocator;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int AMP_W   = 16;
  localparam int HUE_W   = 8;
  localparam int CW      = $clog2(LEDS);
  localparam int LAT     = BIN_QTY * ($clog2(LEDS + 1) + 2) + 1;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [BIN_QTY-1:0][AMP_W-1:0]     amplitudes;
  logic [BIN_QTY-1:0][HUE_W-1:0]     hues;
  logic                              in_valid;
  logic                              busy;
  logic [BIN_QTY-1:0][23:0]          rgb;
  logic [BIN_QTY-1:0][CW-1:0]        led_counts;
  logic                              start;
  logic                              frame_done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int          amp_v[BIN_QTY];
  int          hue_v[BIN_QTY];
  int          exp_cnt[BIN_QTY];
  logic [23:0] exp_rgb[BIN_QTY];
  bit          exp_start;

  always #5 clk = ~clk;

  led_allocator #(
    .LEDS    (LEDS),
    .BIN_QTY (BIN_QTY),
    .AMP_W   (AMP_W),
    .HUE_W   (HUE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .amplitudes (amplitudes),
    .hues       (hues),
    .in_valid   (in_valid),
    .busy       (busy),
    .rgb        (rgb),
    .LEDCounts  (led_counts),
    .start      (start),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int h);
    int r, g, b;
    if (h < 85) begin
      r = 255 - 3 * h; g = 3 * h; b = 0;
    end else if (h < 170) begin
      r = 0; g = 255 - 3 * (h - 85); b = 3 * (h - 85);
    end else begin
      r = 3 * (h - 170); g = 0; b = 255 - 3 * (h - 170);
    end
    return 24'((r << 16) | (g << 8) | b);
  endfunction

  task automatic check_outputs(input string tag);
    int sum;
    sum = 0;
    for (int i = 0; i < BIN_QTY; i++) begin
      chk($sformatf("%s_cnt[%0d]", tag, i), 64'(led_counts[i]), 64'(exp_cnt[i]));
      chk($sformatf("%s_rgb[%0d]", tag, i), 64'(rgb[i]), 64'(exp_rgb[i]));
      sum += int'(led_counts[i]);
    end
    chk({tag, "_start"}, 64'(start), 64'(exp_start));
    chk({tag, "_sum_le_leds"}, 64'(sum <= LEDS), 64'd1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < BIN_QTY; i++) begin
      exp_cnt[i] = 0;
      exp_rgb[i] = 24'h0;
    end
    exp_start = 1'b0;
  endtask

  task automatic load_inputs();
    for (int i = 0; i < BIN_QTY; i++) begin
      amplitudes[i] = AMP_W'(amp_v[i]);
      hues[i]       = HUE_W'(hue_v[i]);
    end
  endtask

  // Starts a frame from amp_v/hue_v, waits for frame_done (bounded), then
  // checks latency and all outputs. Optionally fires a second request while
  // busy, which must have no effect.
  task automatic run_frame(input string tag, input bit inject);
    longint      tot, q;
    int          nc[BIN_QTY];
    logic [23:0] nr[BIN_QTY];
    int          n;
    bit          seen;
    tot = 0;
    for (int i = 0; i < BIN_QTY; i++) tot += amp_v[i];
    for (int i = 0; i < BIN_QTY; i++) begin
      q = (tot == 0) ? 0 : (longint'(amp_v[i]) * LEDS) / tot;
      if (q > (2 ** CW) - 1) q = (2 ** CW) - 1;
      nc[i] = int'(q);
      nr[i] = ref_rgb(hue_v[i]);
    end
    load_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    n = 0;
    seen = 1'b0;
    while (n < LAT + 20 && !seen) begin
      if (inject && n == 10) begin
        in_valid = 1'b1;
        for (int i = 0; i < BIN_QTY; i++) begin
          amplitudes[i] = AMP_W'($urandom);
          hues[i]       = HUE_W'($urandom);
        end
      end
      @(posedge clk);
      n++;
      #1;
      in_valid = 1'b0;
      if (frame_done) begin
        seen = 1'b1;
      end else if (n == 50) begin
        chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
        chk({tag, "_hold_cnt0"}, 64'(led_counts[0]), 64'(exp_cnt[0]));
        chk({tag, "_hold_rgb0"}, 64'(rgb[0]), 64'(exp_rgb[0]));
        chk({tag, "_hold_start"}, 64'(start), 64'(exp_start));
      end else if (n == LAT - 1) begin
        chk({tag, "_busy_last"}, 64'(busy), 64'd1);
      end
    end
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    for (int i = 0; i < BIN_QTY; i++) begin
      exp_cnt[i] = nc[i];
      exp_rgb[i] = nr[i];
    end
    exp_start = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    amplitudes = '0;
    hues       = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    check_outputs("rst");

    // Single nonzero bin takes the whole string.
    for (int i = 0; i < BIN_QTY; i++) begin amp_v[i] = 0; hue_v[i] = 0; end
    amp_v[0] = 100;
    run_frame("solo", 1'b0);
    chk("solo_cnt0_const", 64'(led_counts[0]), 64'd50);
    chk("solo_rgb0_const", 64'(rgb[0]), 64'hFF0000);

    // Two bins 300/100 -> 37 and 12.
    for (int i = 0; i < BIN_QTY; i++) begin amp_v[i] = 0; hue_v[i] = int'($urandom_range(0, 255)); end
    amp_v[0] = 300;
    amp_v[1] = 100;
    run_frame("pair", 1'b0);
    chk("pair_cnt0_const", 64'(led_counts[0]), 64'd37);
    chk("pair_cnt1_const", 64'(led_counts[1]), 64'd12);

    // All-zero amplitudes, hue boundaries.
    for (int i = 0; i < BIN_QTY; i++) begin amp_v[i] = 0; hue_v[i] = int'($urandom_range(0, 255)); end
    hue_v[0] = 42; hue_v[1] = 85; hue_v[2] = 170; hue_v[3] = 255;
    run_frame("zero", 1'b0);
    chk("hue42", 64'(rgb[0]), 64'h817E00);
    chk("hue85", 64'(rgb[1]), 64'h00FF00);
    chk("hue170", 64'(rgb[2]), 64'h0000FF);
    chk("hue255", 64'(rgb[3]), 64'hFF0000);

    // Request while busy is dropped.
    for (int i = 0; i < BIN_QTY; i++) begin
      amp_v[i] = int'($urandom_range(0, 5000));
      hue_v[i] = int'($urandom_range(0, 255));
    end
    run_frame("inject", 1'b1);

    // Reset during DIV aborts the frame.
    for (int i = 0; i < BIN_QTY; i++) begin
      amp_v[i] = int'($urandom_range(1, 1000));
      hue_v[i] = int'($urandom_range(0, 255));
    end
    load_inputs();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_frame_done", 64'(frame_done), 64'd0);
    check_outputs("abort");
    run_frame("after_abort", 1'b0);

    // Randomized back-to-back frames.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < BIN_QTY; i++) begin
        case ($urandom_range(0, 3))
          0:       amp_v[i] = 0;
          1:       amp_v[i] = int'($urandom_range(0, 65535));
          default: amp_v[i] = int'($urandom_range(0, 400));
        endcase
        hue_v[i] = int'($urandom_range(0, 255));
      end
      run_frame($sformatf("rnd%0d", f), f[0]);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
